// File: rtl/piso_pingpong_buf_if.sv
// Handshake bundle for the ping-pong coefficient buffer: parallel beat input,
// serial coefficient output and per-bank occupancy flags.
interface piso_pingpong_buf_if #(
    parameter int unsigned W     = 12,
    parameter int unsigned LANES = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 order_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic                 out_last;
    logic [1:0]           bank_full;

    modport master (
        output in_valid, in_data, order_sel, out_ready,
        input  in_ready, out_valid, out_data, out_last, bank_full
    );

    modport slave (
        input  in_valid, in_data, order_sel, out_ready,
        output in_ready, out_valid, out_data, out_last, bank_full
    );
endinterface

// File: rtl/piso_pingpong_buf.sv
// Two-bank ping-pong store: LANES-wide beats fill one bank while the other
// drains one coefficient per cycle in row-major or lane-major order.
module piso_pingpong_buf #(
    parameter int unsigned W     = 12,
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    piso_pingpong_buf_if.slave     bus
);
    localparam int unsigned LB = $clog2(LANES);
    localparam int unsigned DB = $clog2(DEPTH);
    localparam int unsigned KW = LB + DB;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_st_e;

    bank_st_e        bank_q [2];
    logic            wb_q;
    logic            rb_q;
    logic [DB-1:0]   wr_row_q;
    logic [KW-1:0]   rd_idx_q;
    rd_st_e          rd_st_q;
    logic            ord_q;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic            out_last_q;

    logic [W-1:0]    mem_q [2*DEPTH][LANES];

    logic            in_ready;
    logic            wr_en;
    logic            out_hs;
    logic            rd_last;
    logic            other_full;

    logic            rd_bank_d;
    logic [KW-1:0]   rd_k_d;
    logic            rd_ord_d;
    logic [DB-1:0]   rd_row_d;
    logic [LB-1:0]   rd_lane_d;
    logic [W-1:0]    rd_word_d;

    assign in_ready   = (bank_q[wb_q] == B_EMPTY) || (bank_q[wb_q] == B_FILLING);
    assign wr_en      = bus.in_valid && in_ready;
    assign out_hs     = out_valid_q && bus.out_ready;
    assign rd_last    = out_hs && (&rd_idx_q);
    assign other_full = (bank_q[~rb_q] == B_FULL);

    // Element to present next: either the following index of the current bank
    // or element 0 of a bank just being started (which re-latches order_sel).
    always_comb begin
        rd_bank_d = rb_q;
        rd_k_d    = rd_idx_q + 1'b1;
        rd_ord_d  = ord_q;
        if (rd_st_q == RD_IDLE) begin
            rd_k_d   = '0;
            rd_ord_d = bus.order_sel;
        end else if (rd_last) begin
            rd_bank_d = ~rb_q;
            rd_k_d    = '0;
            rd_ord_d  = bus.order_sel;
        end
        if (!rd_ord_d) begin
            rd_row_d  = rd_k_d[KW-1:LB];
            rd_lane_d = rd_k_d[LB-1:0];
        end else begin
            rd_lane_d = rd_k_d[KW-1:DB];
            rd_row_d  = rd_k_d[DB-1:0];
        end
        rd_word_d = mem_q[{rd_bank_d, rd_row_d}][rd_lane_d];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                mem_q[{wb_q, wr_row_q}][LB'(i)] <= bus.in_data[i*W +: W];
            end
        end
    end

    // Write and read sides never touch the same bank in one cycle: the write
    // bank is EMPTY/FILLING while the read side only acts on FULL/DRAINING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]   <= B_EMPTY;
            bank_q[1]   <= B_EMPTY;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wr_row_q    <= '0;
            rd_idx_q    <= '0;
            rd_st_q     <= RD_IDLE;
            ord_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_row_q <= wr_row_q + 1'b1;
                if (&wr_row_q) begin
                    bank_q[wb_q] <= B_FULL;
                    wb_q         <= ~wb_q;
                end else begin
                    bank_q[wb_q] <= B_FILLING;
                end
            end

            case (rd_st_q)
                RD_IDLE: begin
                    if (bank_q[rb_q] == B_FULL) begin
                        bank_q[rb_q] <= B_DRAINING;
                        rd_st_q      <= RD_STREAM;
                        rd_idx_q     <= '0;
                        ord_q        <= rd_ord_d;
                        out_valid_q  <= 1'b1;
                        out_data_q   <= rd_word_d;
                        out_last_q   <= 1'b0;
                    end
                end
                RD_STREAM: begin
                    if (out_hs) begin
                        if (rd_last) begin
                            bank_q[rb_q] <= B_EMPTY;
                            rb_q         <= ~rb_q;
                            rd_idx_q     <= '0;
                            out_last_q   <= 1'b0;
                            if (other_full) begin
                                bank_q[~rb_q] <= B_DRAINING;
                                ord_q         <= rd_ord_d;
                                out_data_q    <= rd_word_d;
                            end else begin
                                rd_st_q     <= RD_IDLE;
                                out_valid_q <= 1'b0;
                            end
                        end else begin
                            rd_idx_q   <= rd_k_d;
                            out_data_q <= rd_word_d;
                            out_last_q <= &rd_k_d;
                        end
                    end
                end
                default: rd_st_q <= RD_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.bank_full = {(bank_q[1] == B_FULL) || (bank_q[1] == B_DRAINING),
                            (bank_q[0] == B_FULL) || (bank_q[0] == B_DRAINING)};
endmodule

// File: tb/tb_piso_pingpong_buf.sv
// Self-checking bench for piso_pingpong_buf: directed scenarios plus random
// traffic, checked every cycle against a bank-occupancy/queue reference model.
module tb_piso_pingpong_buf;
    localparam int unsigned W     = 12;
    localparam int unsigned LANES = 8;
    localparam int unsigned DEPTH = 16;
    localparam int          TOT   = LANES * DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_pingpong_buf_if #(.W(W), .LANES(LANES)) ifc ();

    piso_pingpong_buf #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: n = banks holding a complete polynomial, rb = oldest of them
    int              m_n, m_rb, m_wrow, m_k;
    bit              m_pres, m_ord;
    logic [W-1:0]    m_mem [2][TOT];

    function automatic logic [W-1:0] m_elem(input int b, input int k, input bit ord);
        int row, lane;
        if (!ord) begin row = k / LANES; lane = k % LANES; end
        else      begin lane = k / DEPTH; row = k % DEPTH; end
        return m_mem[b][row*LANES + lane];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_rb = 0; m_wrow = 0; m_k = 0; m_pres = 0; m_ord = 0;
        end else begin
            int n0, wb;
            bit rd_done, wr_done;
            n0 = m_n; wb = (m_rb + n0) % 2; rd_done = 0; wr_done = 0;
            if (ifc.in_valid && n0 < 2) begin
                for (int i = 0; i < LANES; i++) m_mem[wb][m_wrow*LANES + i] = ifc.in_data[i*W +: W];
                m_wrow++;
                if (m_wrow == DEPTH) begin m_wrow = 0; wr_done = 1; end
            end
            if (m_pres) begin
                if (ifc.out_ready) begin
                    if (m_k == TOT-1) begin
                        rd_done = 1;
                        m_rb ^= 1;
                        if (n0 == 2) begin m_k = 0; m_ord = ifc.order_sel; end
                        else m_pres = 0;
                    end else m_k++;
                end
            end else if (n0 >= 1) begin
                m_pres = 1; m_k = 0; m_ord = ifc.order_sel;
            end
            m_n = n0 - int'(rd_done) + int'(wr_done);
        end
    end

    int           cyc = 0;
    int           rise_cyc = -1, run = 0, max_run = 0, last_cnt = 0;
    bit           prev_valid = 0;
    logic [W-1:0] cap [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0] exp_bf;
            exp_bf = 2'b00;
            if (m_n >= 1) exp_bf[m_rb] = 1'b1;
            if (m_n == 2) exp_bf[m_rb ^ 1] = 1'b1;
            chk("out_valid", 32'(ifc.out_valid), 32'(m_pres));
            chk("in_ready", 32'(ifc.in_ready), 32'(m_n < 2));
            chk("bank_full", 32'(ifc.bank_full), 32'(exp_bf));
            if (m_pres) begin
                chk("out_data", 32'(ifc.out_data), 32'(m_elem(m_rb, m_k, m_ord)));
                chk("out_last", 32'(ifc.out_last), 32'(m_k == TOT-1));
            end
            if (ifc.out_valid && !prev_valid) rise_cyc = cyc;
            run = ifc.out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (ifc.out_valid && ifc.out_ready) begin
                cap.push_back(ifc.out_data);
                if (ifc.out_last) last_cnt++;
            end
            prev_valid = ifc.out_valid;
        end else begin
            prev_valid = 0;
            run = 0;
        end
    end

    int acc_cyc;

    task automatic send_beat(input logic [LANES*W-1:0] d);
        bit ok = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk);
            ok = ifc.in_ready;
            if (ok) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        chk("beat_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_bank(input int base);
        logic [LANES*W-1:0] d;
        for (int r = 0; r < DEPTH; r++) begin
            for (int i = 0; i < LANES; i++) d[i*W +: W] = W'(base + r*16 + i);
            send_beat(d);
        end
    endtask

    task automatic wait_lasts(input int tgt);
        for (int t = 0; t < 5000 && last_cnt < tgt; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", 32'(last_cnt >= tgt), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pop_n(input int n);
        int cnt = 0;
        ifc.out_ready = 1'b1;
        for (int t = 0; t < 1000 && cnt < n; t++) begin
            @(negedge clk);
            if (ifc.out_valid) cnt++;
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1'b0;
    endtask

    task automatic new_phase();
        cap.delete();
        last_cnt = 0;
        max_run  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.order_sel = 1'b0; ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_data", 32'(ifc.out_data), 32'd0);
        chk("rst_bank_full", 32'(ifc.bank_full), 32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

        // Row-major single bank
        new_phase();
        send_bank(0);
        wait_lasts(1);
        chk("t1_latency", 32'(rise_cyc), 32'(acc_cyc + 2));
        chk("t1_count", 32'(cap.size()), 32'(TOT));
        chk("t1_k7", 32'(cap[7]), 32'd7);
        chk("t1_k8", 32'(cap[8]), 32'd16);
        chk("t1_k127", 32'(cap[127]), 32'd247);
        chk("t1_lasts", 32'(last_cnt), 32'd1);

        // Lane-major single bank
        new_phase();
        ifc.order_sel = 1'b1;
        send_bank(0);
        wait_lasts(1);
        chk("t2_k1", 32'(cap[1]), 32'd16);
        chk("t2_k15", 32'(cap[15]), 32'd240);
        chk("t2_k16", 32'(cap[16]), 32'd1);
        chk("t2_k127", 32'(cap[127]), 32'd247);

        // Back-to-back polynomials
        new_phase();
        ifc.order_sel = 1'b0;
        send_bank(0);
        send_bank(1000);
        wait_lasts(2);
        chk("t3_run", 32'(max_run), 32'd256);
        chk("t3_count", 32'(cap.size()), 32'd256);
        chk("t3_k128", 32'(cap[128]), 32'd1000);
        chk("t3_lasts", 32'(last_cnt), 32'd2);

        // Backpressure with both banks full
        new_phase();
        ifc.out_ready = 1'b0;
        send_bank(0);
        send_bank(1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t4_in_ready_full", 32'(ifc.in_ready), 32'd0);
        chk("t4_bank_full", 32'(ifc.bank_full), 32'd3);
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = '1;
        repeat (4) @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        pop_n(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_data", 32'(ifc.out_data), 32'd3);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        wait_lasts(2);
        chk("t4_count", 32'(cap.size()), 32'd256);
        chk("t4_k3", 32'(cap[3]), 32'd3);
        chk("t4_k4", 32'(cap[4]), 32'd4);
        chk("t4_k128", 32'(cap[128]), 32'd1000);

        // Reset while draining
        new_phase();
        send_bank(0);
        for (int t = 0; t < 1000 && cap.size() < 50; t++) begin
            @(posedge clk); #1;
        end
        chk("t5_reached_k50", 32'(cap.size()), 32'd50);
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("t5_bank_full", 32'(ifc.bank_full), 32'd0);
        chk("t5_in_ready", 32'(ifc.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        new_phase();
        @(posedge clk); #1;
        send_bank(2000);
        wait_lasts(1);
        chk("t5_count", 32'(cap.size()), 32'(TOT));
        chk("t5_k0", 32'(cap[0]), 32'd2000);
        chk("t5_k127", 32'(cap[127]), 32'd2247);

        // order_sel flip mid-bank
        new_phase();
        ifc.order_sel = 1'b0;
        send_bank(0);
        for (int t = 0; t < 1000 && cap.size() < 10; t++) begin
            @(posedge clk); #1;
        end
        ifc.order_sel = 1'b1;
        send_bank(1000);
        wait_lasts(2);
        chk("t6_k1", 32'(cap[1]), 32'd1);
        chk("t6_k10", 32'(cap[10]), 32'd18);
        chk("t6_k129", 32'(cap[129]), 32'd1016);
        chk("t6_k144", 32'(cap[144]), 32'd1001);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [LANES*W-1:0] d;
            for (int i = 0; i < LANES; i++) d[i*W +: W] = W'($urandom);
            ifc.in_data   = d;
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) ifc.order_sel = ~ifc.order_sel;
            @(posedge clk); #1;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (400) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
